sap_controller: RTL and testbench
=================================

Name: sap_controller

Overview:
- Controller-sequencer for the 8-bit bus machine: a six-T-state ring sequencer plus a control matrix.
- Drives the active-low load/enable lines of the bus registers, the PC increment, the ALU subtract select and halt.
- Sits directly upstream of every register stage. Consumes the opcode nibble from the instruction register.

Parameters:
- OPCODE_W, 4, opcode width taken from the instruction register's upper nibble.
- NUM_T, 6, T-states per instruction (fixed machine cycle).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- resetbar  in  1  synchronous reset, active-low, sampled on posedge clk.
- opcode  in  OPCODE_W  current instruction opcode from the IR.
- pc_inc  out  1  PC increment (active-high).
- pc_enablebar  out  1  PC drives bus.
- mar_loadbar  out  1  MAR load.
- ram_enablebar  out  1  RAM drives bus.
- ir_loadbar  out  1  IR load.
- ir_enablebar  out  1  IR operand nibble drives bus.
- a_loadbar  out  1  accumulator load.
- a_enablebar  out  1  accumulator drives bus.
- b_loadbar  out  1  B register load.
- alu_sub  out  1  ALU subtract select (1 = A-B).
- alu_enablebar  out  1  ALU drives bus.
- out_loadbar  out  1  output register load.
- halt  out  1  machine halted.
- t_state  out  NUM_T  one-hot current T-state (debug); all-zero in RST/HALT.

Behaviour:
- States: RST, T1..T6, HALT. Registered. Outputs are a combinational decode of (state, opcode).
- Inactive control word: all *bar = 1, pc_inc = 0, alu_sub = 0, halt = 0.
- Reset: resetbar = 0 at posedge puts the controller in RST. This applies from any state, including mid-instruction and HALT. RST drives the inactive word and t_state = 0.
- Transitions: RST -> T1 -> T2 -> ... -> T6 -> T1. One cycle each, so one instruction takes 6 cycles.
- T4 with HLT -> HALT.
- HALT is sticky: halt = 1, all other controls inactive, t_state = 0. Only reset leaves HALT.
- Timing contract: controls are valid for the whole T-state. Consumers act at the posedge that ends it.
- Opcodes: LDA = 0000, ADD = 0001, SUB = 0010, OUT = 1110, HLT = 1111. Any other opcode is a NOP, with inactive T4..T6.
- Fetch, for every opcode:
  - T1: pc_enablebar = 0, mar_loadbar = 0.
  - T2: pc_inc = 1.
  - T3: ram_enablebar = 0, ir_loadbar = 0.
- T4:
  - LDA/ADD/SUB: ir_enablebar = 0, mar_loadbar = 0.
  - OUT: a_enablebar = 0, out_loadbar = 0.
  - HLT: inactive; next state is HALT.
- T5:
  - LDA: ram_enablebar = 0, a_loadbar = 0.
  - ADD/SUB: ram_enablebar = 0, b_loadbar = 0.
  - Others: inactive.
- T6:
  - ADD: alu_enablebar = 0, a_loadbar = 0.
  - SUB: the same plus alu_sub = 1.
  - Others: inactive.
- Bus rule: at most one *_enablebar low in any cycle. Violation is a design error, covered by an assertion.
- Opcode is sampled combinationally. It only needs to be stable from T4 to T6, because the IR loads at the end of T3.

Optional Feature:
- Macro SAP_CTRL_SINGLE_STEP_EN adds input `step` (1 bit).
- With the macro:
  - T1..T6 advance only in cycles where step = 1.
  - The decoded control word is forced inactive in any cycle with step = 0. This prevents repeated pc_inc or reloads while paused.
  - RST -> T1 and reset behave the same as without the macro.
- Without the macro: no `step` port; the controller advances every cycle.

Decomposition:
- Shared package sap_pkg holds:
  - opcode localparams (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - state encoding;
  - control-word bit-index constants;
  - the CTRL_INACTIVE word.
- Sub-module sap_ring_counter: one-hot T-state ring with synchronous active-low clear, advance enable and halt hold. The control matrix stays in sap_controller.

Test Plan:
- Reset: hold resetbar = 0 for 2 cycles, then release -> one cycle of RST (inactive word, t_state = 0), then T1 with pc_enablebar = 0 and mar_loadbar = 0.
- LDA (opcode = 0000) -> T4 ir_enablebar = mar_loadbar = 0; T5 ram_enablebar = a_loadbar = 0; T6 inactive; next cycle t_state = 000001.
- SUB (opcode = 0010) -> T5 b_loadbar = 0; T6 alu_enablebar = a_loadbar = 0 with alu_sub = 1. ADD gives the same with alu_sub = 0.
- HLT (opcode = 1111) -> halt = 1 from the cycle after T4 and held for more than 20 cycles. Reset then returns to RST/T1 with halt = 0.
- Reset mid-instruction: resetbar = 0 during T5 of ADD -> next cycle RST with all controls inactive, no a_loadbar pulse.
- Single step (macro defined): step = 0 for 5 cycles in T2 -> pc_inc = 0 and t_state held. One step pulse -> exactly one pc_inc and advance to T3.

Source files
------------

// File: rtl/sap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_pkg : opcodes, state encoding and control-word layout for the SAP    |
// | controller.                                              Revision: 1.0   |
// +--------------------------------------------------------------------------+
package sap_pkg;

  localparam int SAP_OPCODE_W = 4;
  localparam int SAP_NUM_T    = 6;

  localparam logic [SAP_OPCODE_W-1:0] OP_LDA = 4'b0000;
  localparam logic [SAP_OPCODE_W-1:0] OP_ADD = 4'b0001;
  localparam logic [SAP_OPCODE_W-1:0] OP_SUB = 4'b0010;
  localparam logic [SAP_OPCODE_W-1:0] OP_OUT = 4'b1110;
  localparam logic [SAP_OPCODE_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_HALT = 3'd7
  } sap_state_e;

  localparam int CW_W          = 13;
  localparam int CW_PC_INC     = 0;
  localparam int CW_PC_ENB     = 1;
  localparam int CW_MAR_LDB    = 2;
  localparam int CW_RAM_ENB    = 3;
  localparam int CW_IR_LDB     = 4;
  localparam int CW_IR_ENB     = 5;
  localparam int CW_A_LDB      = 6;
  localparam int CW_A_ENB      = 7;
  localparam int CW_B_LDB      = 8;
  localparam int CW_ALU_SUB    = 9;
  localparam int CW_ALU_ENB    = 10;
  localparam int CW_OUT_LDB    = 11;
  localparam int CW_HALT       = 12;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Every *bar high, pc_inc / alu_sub / halt low.
  localparam ctrl_word_t CTRL_INACTIVE = 13'b0_1101_1111_1110;

  // An all-zero ring is RST unless the halted flag is set.
  function automatic sap_state_e ring_to_state(input logic [SAP_NUM_T-1:0] ring,
                                               input logic                 halted);
    sap_state_e st;
    st = ST_RST;
    if (halted) begin
      st = ST_HALT;
    end else begin
      for (int i = 0; i < SAP_NUM_T; i++) begin
        if (ring[i]) st = sap_state_e'(3'(i + 1));
      end
    end
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sap_ring_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_ring_counter : one-hot T-state ring with sync active-low clear,      |
// | advance enable and sticky halt.                          Revision: 1.0   |
// +--------------------------------------------------------------------------+
module sap_ring_counter #(
  parameter int NUM_T = 6
) (
  input  logic             clk,
  input  logic             resetbar,
  input  logic             advance,
  input  logic             halt_req,
  output logic [NUM_T-1:0] ring,
  output logic             halted
);

  logic [NUM_T-1:0] ring_d, ring_q;
  logic             halted_d, halted_q;

  always_ff @(posedge clk) begin
    if (!resetbar) begin
      ring_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    ring_d   = ring_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (halt_req) begin
        ring_d   = '0;
        halted_d = 1'b1;
      end else if (ring_q == '0) begin
        // Leaving RST is unconditional, even while single-stepping.
        ring_d = NUM_T'(1);
      end else if (advance) begin
        ring_d = {ring_q[NUM_T-2:0], ring_q[NUM_T-1]};
      end
    end
  end

  assign ring   = ring_q;
  assign halted = halted_q;

endmodule
`default_nettype wire

// File: rtl/sap_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_controller : six-T-state sequencer and control matrix for the SAP    |
// | bus machine. Optional SAP_CTRL_SINGLE_STEP_EN adds a `step` input.       |
// |                                                          Revision: 1.0   |
// +--------------------------------------------------------------------------+
module sap_controller
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int NUM_T    = 6
) (
  input  logic                clk,
  input  logic                resetbar,
  input  logic [OPCODE_W-1:0] opcode,
`ifdef SAP_CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                pc_inc,
  output logic                pc_enablebar,
  output logic                mar_loadbar,
  output logic                ram_enablebar,
  output logic                ir_loadbar,
  output logic                ir_enablebar,
  output logic                a_loadbar,
  output logic                a_enablebar,
  output logic                b_loadbar,
  output logic                alu_sub,
  output logic                alu_enablebar,
  output logic                out_loadbar,
  output logic                halt,
  output logic [NUM_T-1:0]    t_state
);

  logic             advance;
  logic             halt_req;
  logic [NUM_T-1:0] ring;
  logic             halted;
  sap_state_e       state;
  ctrl_word_t       cw;

`ifdef SAP_CTRL_SINGLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  assign state    = ring_to_state(ring, halted);
  assign halt_req = (state == ST_T4) && (opcode == OPCODE_W'(OP_HLT)) && advance;

  sap_ring_counter #(
    .NUM_T (NUM_T)
  ) u_ring (
    .clk      (clk),
    .resetbar (resetbar),
    .advance  (advance),
    .halt_req (halt_req),
    .ring     (ring),
    .halted   (halted)
  );

  always_comb begin
    cw = CTRL_INACTIVE;
    case (state)
      ST_T1: begin
        cw[CW_PC_ENB]  = 1'b0;
        cw[CW_MAR_LDB] = 1'b0;
      end
      ST_T2: cw[CW_PC_INC] = 1'b1;
      ST_T3: begin
        cw[CW_RAM_ENB] = 1'b0;
        cw[CW_IR_LDB]  = 1'b0;
      end
      ST_T4: begin
        if (opcode == OPCODE_W'(OP_LDA) || opcode == OPCODE_W'(OP_ADD) ||
            opcode == OPCODE_W'(OP_SUB)) begin
          cw[CW_IR_ENB]  = 1'b0;
          cw[CW_MAR_LDB] = 1'b0;
        end else if (opcode == OPCODE_W'(OP_OUT)) begin
          cw[CW_A_ENB]   = 1'b0;
          cw[CW_OUT_LDB] = 1'b0;
        end
      end
      ST_T5: begin
        if (opcode == OPCODE_W'(OP_LDA)) begin
          cw[CW_RAM_ENB] = 1'b0;
          cw[CW_A_LDB]   = 1'b0;
        end else if (opcode == OPCODE_W'(OP_ADD) || opcode == OPCODE_W'(OP_SUB)) begin
          cw[CW_RAM_ENB] = 1'b0;
          cw[CW_B_LDB]   = 1'b0;
        end
      end
      ST_T6: begin
        if (opcode == OPCODE_W'(OP_ADD) || opcode == OPCODE_W'(OP_SUB)) begin
          cw[CW_ALU_ENB] = 1'b0;
          cw[CW_A_LDB]   = 1'b0;
          cw[CW_ALU_SUB] = (opcode == OPCODE_W'(OP_SUB));
        end
      end
      ST_HALT: cw[CW_HALT] = 1'b1;
      default: cw = CTRL_INACTIVE;
    endcase
`ifdef SAP_CTRL_SINGLE_STEP_EN
    // A paused T-state must not repeat pc_inc or register loads.
    if (!step && state != ST_RST && state != ST_HALT) cw = CTRL_INACTIVE;
`endif
  end

  assign pc_inc        = cw[CW_PC_INC];
  assign pc_enablebar  = cw[CW_PC_ENB];
  assign mar_loadbar   = cw[CW_MAR_LDB];
  assign ram_enablebar = cw[CW_RAM_ENB];
  assign ir_loadbar    = cw[CW_IR_LDB];
  assign ir_enablebar  = cw[CW_IR_ENB];
  assign a_loadbar     = cw[CW_A_LDB];
  assign a_enablebar   = cw[CW_A_ENB];
  assign b_loadbar     = cw[CW_B_LDB];
  assign alu_sub       = cw[CW_ALU_SUB];
  assign alu_enablebar = cw[CW_ALU_ENB];
  assign out_loadbar   = cw[CW_OUT_LDB];
  assign halt          = cw[CW_HALT];
  assign t_state       = ring;

  a_single_bus_driver: assert property (@(posedge clk) disable iff (!resetbar)
    $onehot0(~{pc_enablebar, ram_enablebar, ir_enablebar, a_enablebar, alu_enablebar}));

endmodule
`default_nettype wire

// File: tb/tb_sap_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sap_controller : directed bench with a cycle-level reference model    |
// | of the SAP controller.                                   Revision: 1.0   |
// +--------------------------------------------------------------------------+
module tb_sap_controller;

  logic       clk      = 1'b0;
  logic       resetbar = 1'b0;
  logic [3:0] opcode   = 4'h0;
  logic       step     = 1'b1;

  logic       pc_inc, pc_enablebar, mar_loadbar, ram_enablebar, ir_loadbar;
  logic       ir_enablebar, a_loadbar, a_enablebar, b_loadbar, alu_sub;
  logic       alu_enablebar, out_loadbar, halt;
  logic [5:0] t_state;
  logic [12:0] dut_cw;

  int checks = 0;
  int errors = 0;
  int ph     = -1;  // model phase: 0 RST, 1..6 T-states, 7 HALT, -1 unknown

  localparam logic [12:0] INACTIVE = 13'h0DFE;

  always #5 clk = ~clk;

  sap_controller dut (
    .clk           (clk),
    .resetbar      (resetbar),
    .opcode        (opcode),
`ifdef SAP_CTRL_SINGLE_STEP_EN
    .step          (step),
`endif
    .pc_inc        (pc_inc),
    .pc_enablebar  (pc_enablebar),
    .mar_loadbar   (mar_loadbar),
    .ram_enablebar (ram_enablebar),
    .ir_loadbar    (ir_loadbar),
    .ir_enablebar  (ir_enablebar),
    .a_loadbar     (a_loadbar),
    .a_enablebar   (a_enablebar),
    .b_loadbar     (b_loadbar),
    .alu_sub       (alu_sub),
    .alu_enablebar (alu_enablebar),
    .out_loadbar   (out_loadbar),
    .halt          (halt),
    .t_state       (t_state)
  );

  assign dut_cw = {halt, out_loadbar, alu_enablebar, alu_sub, b_loadbar, a_enablebar,
                   a_loadbar, ir_enablebar, ir_loadbar, ram_enablebar, mar_loadbar,
                   pc_enablebar, pc_inc};

  function automatic logic [12:0] exp_cw(input int p, input logic [3:0] op, input logic stp);
    logic inc = 1'b0, pce = 1'b1, marl = 1'b1, rame = 1'b1, irl = 1'b1, ire = 1'b1;
    logic al = 1'b1, ae = 1'b1, bl = 1'b1, sub = 1'b0, alue = 1'b1, outl = 1'b1, hlt = 1'b0;
    logic alu_op;
    alu_op = (op == 4'h1) || (op == 4'h2);
    if (p == 7) begin
      hlt = 1'b1;
    end else if (p >= 1 && p <= 6 && stp) begin
      case (p)
        1: begin pce = 1'b0; marl = 1'b0; end
        2: inc = 1'b1;
        3: begin rame = 1'b0; irl = 1'b0; end
        4: if (op == 4'h0 || alu_op) begin ire = 1'b0; marl = 1'b0; end
           else if (op == 4'hE) begin ae = 1'b0; outl = 1'b0; end
        5: if (op == 4'h0) begin rame = 1'b0; al = 1'b0; end
           else if (alu_op) begin rame = 1'b0; bl = 1'b0; end
        6: if (alu_op) begin alue = 1'b0; al = 1'b0; sub = (op == 4'h2); end
        default: ;
      endcase
    end
    return {hlt, outl, alue, sub, bl, ae, al, ire, irl, rame, marl, pce, inc};
  endfunction

  function automatic logic [5:0] exp_t(input int p);
    logic [5:0] one;
    one = 6'b000001;
    return (p >= 1 && p <= 6) ? (one << (p - 1)) : 6'b000000;
  endfunction

  // Reference sequencer: what the machine cycle must be after each edge.
  always @(posedge clk) begin
    if (!resetbar)                       ph <= 0;
    else if (ph < 0 || ph == 7)          ph <= ph;
    else if (ph == 0)                    ph <= 1;
    else if (!step)                      ph <= ph;
    else if (ph == 4 && opcode == 4'hF)  ph <= 7;
    else                                 ph <= (ph == 6) ? 1 : ph + 1;
  end

  always @(negedge clk) begin
    if (ph >= 0) begin
      checks++;
      if (dut_cw !== exp_cw(ph, opcode, step)) begin
        errors++;
        $display("FAIL model_cw phase=%0d: got %h expected %h", ph, dut_cw,
                 exp_cw(ph, opcode, step));
      end
      checks++;
      if (t_state !== exp_t(ph)) begin
        errors++;
        $display("FAIL model_t phase=%0d: got %b expected %b", ph, t_state, exp_t(ph));
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic go(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    go(2);
    resetbar = 1'b1;
    chk("rst_t", 16'(t_state), 16'h0);
    chk("rst_cw", 16'(dut_cw), 16'(INACTIVE));
    go(1);
    chk("t1_t", 16'(t_state), 16'h01);
    chk("t1_pce", 16'(pc_enablebar), 16'h0);
    chk("t1_mar", 16'(mar_loadbar), 16'h0);
    go(1);
    chk("t2_inc", 16'(pc_inc), 16'h1);
    go(1);
    chk("t3_ram_ir", 16'({ram_enablebar, ir_loadbar}), 16'h0);
    go(1);
    chk("lda_t4", 16'({ir_enablebar, mar_loadbar}), 16'h0);
    go(1);
    chk("lda_t5", 16'({ram_enablebar, a_loadbar}), 16'h0);
    go(1);
    chk("lda_t6", 16'(dut_cw), 16'(INACTIVE));
    go(1);
    chk("lda_wrap", 16'(t_state), 16'h01);

    opcode = 4'h2;
    go(4);
    chk("sub_t5_b", 16'(b_loadbar), 16'h0);
    go(1);
    chk("sub_t6", 16'({alu_enablebar, a_loadbar, alu_sub}), 16'h1);
    go(1);

    opcode = 4'h1;
    go(5);
    chk("add_t6", 16'({alu_enablebar, a_loadbar, alu_sub}), 16'h0);
    go(1);

    opcode = 4'hE;
    go(3);
    chk("out_t4", 16'({a_enablebar, out_loadbar}), 16'h0);
    go(3);

    opcode = 4'h5;
    go(3);
    chk("nop_t4", 16'(dut_cw), 16'(INACTIVE));
    go(3);

    opcode = 4'h1;
    go(4);
    chk("add_t5_b", 16'(b_loadbar), 16'h0);
    resetbar = 1'b0;
    go(1);
    chk("midrst_cw", 16'(dut_cw), 16'(INACTIVE));
    chk("midrst_t", 16'(t_state), 16'h0);
    resetbar = 1'b1;
    go(1);
    chk("midrst_t1", 16'(t_state), 16'h01);

    opcode = 4'hF;
    go(3);
    chk("hlt_t4", 16'(dut_cw), 16'(INACTIVE));
    go(1);
    chk("halt_on", 16'({halt, t_state}), 16'h40);
    go(22);
    chk("halt_held", 16'({halt, t_state}), 16'h40);
    resetbar = 1'b0;
    go(1);
    chk("halt_rst", 16'({halt, t_state}), 16'h00);
    resetbar = 1'b1;
    go(1);
    chk("halt_rst_t1", 16'(t_state), 16'h01);

`ifdef SAP_CTRL_SINGLE_STEP_EN
    opcode = 4'h0;
    go(1);
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pause_inc", 16'(pc_inc), 16'h0);
      chk("pause_t", 16'(t_state), 16'h02);
      go(1);
    end
    step = 1'b1;
    chk("step_inc", 16'(pc_inc), 16'h1);
    go(1);
    step = 1'b0;
    chk("step_t3", 16'(t_state), 16'h04);
    chk("step_noinc", 16'(pc_inc), 16'h0);
    go(2);
    step = 1'b1;
    go(4);
`endif

    go(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
